// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I subset (R, I-ALU, LW, SW, BEQ).
// Optional memory-ack timeout under `ifdef MC_TIMEOUT_EN; outputs decode from state + latched opcode.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [31:0]      instr_i,
    output logic             imem_req_o,
    input  logic             imem_ack_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    input  logic             dmem_ack_i,
    output logic             pc_we_o,
    output logic             ir_we_o,
    output logic             alu_src_o,
    output logic [1:0]       imm_sel_o,
    output logic             branch_o,
    output logic             reg_we_o,
    output logic             mem_to_reg_o,
    output logic [2:0]       state_o,
    output logic             illegal_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYC);

    state_t           state_q, state_d;
    logic [6:0]       opcode_q;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q;
    logic             tmo;

    logic is_r, is_i, is_lw, is_sw, is_beq, legal;
    assign is_r   = (opcode_q == OP_R);
    assign is_i   = (opcode_q == OP_I);
    assign is_lw  = (opcode_q == OP_LW);
    assign is_sw  = (opcode_q == OP_SW);
    assign is_beq = (opcode_q == OP_BEQ);
    assign legal  = is_r | is_i | is_lw | is_sw | is_beq;

    logic unused_cfg;
    assign unused_cfg = ^{instr_i[31:7], TMO_LIM};

`ifdef MC_TIMEOUT_EN
    logic [7:0] wait_q;
    logic       bus_err_q;
    logic       waiting;
    assign waiting   = ((state_q == ST_FETCH) && !imem_ack_i) ||
                       ((state_q == ST_MEM)   && !dmem_ack_i);
    // An ack on the cycle the count hits the limit still wins, because tmo only matters while waiting.
    assign tmo       = (wait_q == TMO_LIM);
    assign bus_err_o = bus_err_q;
`else
    assign tmo       = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    always_comb begin
        imem_req_o   = 1'b0;
        ir_we_o      = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        pc_we_o      = 1'b0;
        alu_src_o    = 1'b0;
        imm_sel_o    = 2'd0;
        branch_o     = 1'b0;
        reg_we_o     = 1'b0;
        mem_to_reg_o = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req_o = 1'b1;
                ir_we_o    = imem_ack_i;
            end
            ST_EXEC: begin
                alu_src_o = is_i | is_lw | is_sw;
                if (is_sw)       imm_sel_o = 2'd1;
                else if (is_beq) imm_sel_o = 2'd2;
                else if (is_r)   imm_sel_o = 2'd3;
                else             imm_sel_o = 2'd0;
                branch_o  = is_beq;
                pc_we_o   = is_beq;
            end
            ST_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = is_sw;
                pc_we_o    = is_sw & dmem_ack_i;
            end
            ST_WB: begin
                reg_we_o     = 1'b1;
                pc_we_o      = 1'b1;
                mem_to_reg_o = is_lw;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (imem_ack_i) state_d = ST_DECODE;
                       else if (tmo)   state_d = ST_TRAP;
            ST_DECODE: state_d = legal ? ST_EXEC : ST_TRAP;
            ST_EXEC:   if (is_beq)             state_d = ST_FETCH;
                       else if (is_lw | is_sw) state_d = ST_MEM;
                       else                    state_d = ST_WB;
            ST_MEM:    if (dmem_ack_i) state_d = is_lw ? ST_WB : ST_FETCH;
                       else if (tmo)   state_d = ST_TRAP;
            ST_WB:     state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            opcode_q  <= 7'd0;
            retired_q <= '0;
            illegal_q <= 1'b0;
`ifdef MC_TIMEOUT_EN
            wait_q    <= 8'd0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH && imem_ack_i)
                opcode_q <= instr_i[6:0];
            if (pc_we_o)
                retired_q <= retired_q + CNT_W'(1);
            if (state_q == ST_DECODE && !legal)
                illegal_q <= 1'b1;
`ifdef MC_TIMEOUT_EN
            wait_q <= (waiting && !tmo) ? wait_q + 8'd1 : 8'd0;
            if (waiting && tmo)
                bus_err_q <= 1'b1;
`endif
        end
    end

    assign state_o   = state_q;
    assign illegal_o = illegal_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-instruction cycle trace model predicts every output each cycle.
module tb_multicycle_ctrl;

    localparam int TMO = 15;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] instr_i;
    logic        imem_req_o, imem_ack_i, dmem_req_o, dmem_we_o, dmem_ack_i;
    logic        pc_we_o, ir_we_o, alu_src_o, branch_o, reg_we_o, mem_to_reg_o;
    logic [1:0]  imm_sel_o;
    logic [2:0]  state_o;
    logic        illegal_o, bus_err_o;
    logic [31:0] retired_o;

    multicycle_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .instr_i(instr_i),
        .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
        .pc_we_o(pc_we_o), .ir_we_o(ir_we_o), .alu_src_o(alu_src_o),
        .imm_sel_o(imm_sel_o), .branch_o(branch_o), .reg_we_o(reg_we_o),
        .mem_to_reg_o(mem_to_reg_o), .state_o(state_o), .illegal_o(illegal_o),
        .bus_err_o(bus_err_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       imem_req, ir_we, dmem_req, dmem_we, pc_we, alu_src;
        logic [1:0] imm_sel;
        logic       branch, reg_we, mem_to_reg, illegal, bus_err;
        logic [2:0] state;
    } obs_t;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [31:0] exp_ret  = 32'd0;
    obs_t        exp_q[$];
    bit          iack_q[$];
    bit          dack_q[$];
    logic [31:0] ins_cur;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t sample_obs();
        obs_t o;
        o.imem_req = imem_req_o;  o.ir_we = ir_we_o;     o.dmem_req = dmem_req_o;
        o.dmem_we = dmem_we_o;    o.pc_we = pc_we_o;     o.alu_src = alu_src_o;
        o.imm_sel = imm_sel_o;    o.branch = branch_o;   o.reg_we = reg_we_o;
        o.mem_to_reg = mem_to_reg_o; o.illegal = illegal_o; o.bus_err = bus_err_o;
        o.state = state_o;
        return o;
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
               op == 7'b0100011 || op == 7'b1100011;
    endfunction

    // Expected per-cycle outputs for one instruction, from FETCH entry to the cycle before the next FETCH.
    task automatic build_trace(input logic [31:0] ins, input int di, input int dd);
        obs_t       r;
        logic [6:0] op;
        bit         c_r, c_i, c_lw, c_sw, c_beq;
        op = ins[6:0];
        c_r = (op == 7'b0110011); c_i = (op == 7'b0010011); c_lw = (op == 7'b0000011);
        c_sw = (op == 7'b0100011); c_beq = (op == 7'b1100011);
        exp_q.delete(); iack_q.delete(); dack_q.delete();
        ins_cur = ins;
        for (int k = 0; k <= di; k++) begin
            r = '0; r.state = 3'd1; r.imem_req = 1'b1; r.ir_we = (k == di);
            exp_q.push_back(r); iack_q.push_back(k == di); dack_q.push_back(1'b0);
        end
        r = '0; r.state = 3'd2;
        exp_q.push_back(r); iack_q.push_back(1'b0); dack_q.push_back(1'b0);
        if (!is_legal(op)) return;
        r = '0; r.state = 3'd3;
        r.alu_src = c_i | c_lw | c_sw;
        r.imm_sel = c_sw ? 2'd1 : c_beq ? 2'd2 : c_r ? 2'd3 : 2'd0;
        r.branch = c_beq; r.pc_we = c_beq;
        exp_q.push_back(r); iack_q.push_back(1'b0); dack_q.push_back(1'b0);
        if (c_lw || c_sw) begin
            for (int k = 0; k <= dd; k++) begin
                r = '0; r.state = 3'd4; r.dmem_req = 1'b1; r.dmem_we = c_sw;
                r.pc_we = c_sw && (k == dd);
                exp_q.push_back(r); iack_q.push_back(1'b0); dack_q.push_back(k == dd);
            end
        end
        if (c_r || c_i || c_lw) begin
            r = '0; r.state = 3'd5; r.reg_we = 1'b1; r.pc_we = 1'b1; r.mem_to_reg = c_lw;
            exp_q.push_back(r); iack_q.push_back(1'b0); dack_q.push_back(1'b0);
        end
    endtask

    // Acks outside a request window are randomised: the controller must ignore them.
    task automatic run_trace(input int n);
        obs_t e;
        for (int k = 0; k < n; k++) begin
            e = exp_q[k];
            imem_ack_i = e.imem_req ? iack_q[k] : 1'($urandom_range(0, 1));
            dmem_ack_i = e.dmem_req ? dack_q[k] : 1'($urandom_range(0, 1));
            instr_i    = (e.imem_req && iack_q[k]) ? ins_cur : $urandom();
            @(negedge clk_i);
            chk("outs", {48'd0, sample_obs()}, {48'd0, e});
            @(posedge clk_i); #1;
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input int di, input int dd);
        build_trace(ins, di, dd);
        run_trace(exp_q.size());
        if (is_legal(ins[6:0])) exp_ret = exp_ret + 32'd1;
        chk("retired", 64'(retired_o), 64'(exp_ret));
    endtask

    task automatic trap_cycles(input int n, input logic ill, input logic berr);
        obs_t r;
        for (int k = 0; k < n; k++) begin
            imem_ack_i = 1'($urandom_range(0, 1));
            dmem_ack_i = 1'($urandom_range(0, 1));
            instr_i    = $urandom();
            r = '0; r.state = 3'd6; r.illegal = ill; r.bus_err = berr;
            @(negedge clk_i);
            chk("trap", {48'd0, sample_obs()}, {48'd0, r});
            @(posedge clk_i); #1;
        end
        chk("trap_ret", 64'(retired_o), 64'(exp_ret));
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        #1;
        chk("rst_outs", {48'd0, sample_obs()}, 64'd0);
        chk("rst_ret", 64'(retired_o), 64'd0);
        imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
        exp_ret = 32'd0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        chk("idle", {48'd0, sample_obs()}, 64'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  op;
        logic [31:0] ins;
        int          sel;
        rst_n_i = 1'b0; instr_i = 32'd0; imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
        #2;
        do_reset();

        run_instr(32'h00500093, 2, 0);        // addi, ack two cycles after req
        run_instr(32'h00402103, 0, 3);        // lw, dmem ack three cycles late
        run_instr(32'h00202223, 0, 0);        // sw
        run_instr(32'h00000463, 0, 0);        // beq

        build_trace(32'h0000007F, 1, 0);
        run_trace(exp_q.size());
        trap_cycles(4, 1'b1, 1'b0);
        do_reset();

        // Reset asserted mid-MEM of a store abandons the request with no strobe.
        run_instr(32'h00500093, 0, 0);
        build_trace(32'h00202223, 0, 3);
        run_trace(4);
        do_reset();
        run_instr(32'h00000463, 0, 0);

`ifdef MC_TIMEOUT_EN
        for (int k = 0; k <= TMO; k++) begin
            obs_t r;
            imem_ack_i = 1'b0;
            dmem_ack_i = 1'($urandom_range(0, 1));
            r = '0; r.state = 3'd1; r.imem_req = 1'b1;
            @(negedge clk_i);
            chk("tmo_wait", {48'd0, sample_obs()}, {48'd0, r});
            @(posedge clk_i); #1;
        end
        trap_cycles(3, 1'b0, 1'b1);
        do_reset();
        run_instr(32'h00500093, TMO, 0);
        run_instr(32'h00402103, 0, TMO);
`else
        run_instr(32'h00402103, 40, 40);
`endif

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            case (sel % 5)
                0: op = 7'b0110011;
                1: op = 7'b0010011;
                2: op = 7'b0000011;
                3: op = 7'b0100011;
                default: op = 7'b1100011;
            endcase
            if (sel >= 8) begin
                op = 7'($urandom());
                while (is_legal(op)) op = 7'($urandom());
            end
            ins = {25'($urandom()), op};
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3));
            if (!is_legal(op)) begin
                trap_cycles(3, 1'b1, 1'b0);
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
